// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding and the stream framing constants.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  function automatic logic can_start(input state_e s);
    return (s == IDLE) || (s == DONE) || (s == ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte shift-in register: each shifted byte lands in the next lane.
// word_full_o flags the shift that completes a word; the lane counter then wraps.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane_q;
  logic [31:0]       word_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (shift_i) begin
      word_q[8*lane_q +: 8] <= byte_i;
      lane_q                <= lane_q + 1'b1;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = shift_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as 32-bit words,
// holding the core in reset until the whole program has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MEM_WORDS = 17'(1) << DEPTH_LOG2;

  state_e                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [DEPTH_LOG2:0]   word_cnt_q, word_cnt_d;

  logic        xfer;
  logic        start_take;
  logic        word_full;
  logic        last_word;
  logic [15:0] hdr_n;

  assign xfer       = in_valid && in_ready;
  assign start_take = start && can_start(state_q);
  assign hdr_n      = {in_data, count_q[7:0]};
  assign last_word  = (17'(word_cnt_q) + 17'd1) == {1'b0, count_q};

  imem_loader_word_assembler u_asm (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (start_take),
    .shift_i     (xfer && (state_q == DATA)),
    .byte_i      (in_data),
    .word_o      (mem_wdata),
    .word_full_o (word_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start) state_d = HDR_LO;
      HDR_LO:            if (xfer) state_d = HDR_HI;
      HDR_HI: begin
        if (xfer) begin
          if (hdr_n == 16'd0)                state_d = DONE;
          else if ({1'b0, hdr_n} > MEM_WORDS) state_d = ERROR;
          else                               state_d = DATA;
        end
      end
      DATA:    if (xfer && word_full) state_d = WRITE;
      WRITE:   state_d = last_word ? DONE : DATA;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == HDR_LO) || (state_q == HDR_HI) || (state_q == DATA);
    mem_we     = (state_q == WRITE);
    busy       = in_ready || mem_we;
    done       = (state_q == DONE);
    error      = (state_q == ERROR);
    // A start sampled in DONE puts the core back into reset in that same cycle.
    core_reset = !((state_q == DONE) && !start);
  end

  always_comb begin
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    if (start_take) begin
      count_d    = '0;
      word_cnt_d = '0;
    end else begin
      if (xfer && (state_q == HDR_LO)) count_d[7:0]  = in_data;
      if (xfer && (state_q == HDR_HI)) count_d[15:8] = in_data;
      if (state_q == WRITE)            word_cnt_d    = word_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign mem_addr = BASE_ADDR + 32'({word_cnt_q, 2'b00});

endmodule
